wb_protocol_monitor: RTL and testbench
======================================

// Module: wb_protocol_monitor
// PURPOSE
//  Synthesizable, parametrised Wishbone B3 classic-cycle protocol checker. It is a passive tap on the host
//  WB port of the SDRAM controller and drives nothing onto the bus. Checks rules 3.00/3.25/3.35 plus
//  request stability, ACK liveness and SEL validity. Reports sticky per-rule flags, an error pulse and
//  saturating traffic counters; the checks work in silicon as well as in simulation.
// PARAMETERS
//  DW          32  data width, multiple of 8
//  AW          32  address width
//  SW          DW/8  byte-select width (derived)
//  ACK_TIMEOUT 16  consecutive unacked CYC&STB cycles that raise a timeout error; range 2..65535
//  CNT_W       16  width of every counter
// PORTS
//  wb_clk_i    in   1     bus clock; all logic on posedge
//  wb_rst_i    in   1     asynchronous, active-high reset
//  wb_cyc_i    in   1     observed CYC
//  wb_stb_i    in   1     observed STB
//  wb_we_i     in   1     observed WE
//  wb_sel_i    in   SW    observed SEL
//  wb_adr_i    in   AW    observed ADR
//  wb_dat_i    in   DW    observed write data
//  wb_ack_o    in   1     observed slave ACK (monitor input)
//  clr_i       in   1     synchronous clear of flags and counters
//  err_flags_o out  6     sticky flags, bit n = check n
//  err_pulse_o out  1     high 1 cycle for each cycle in which any check fires
//  txn_cnt_o   out  CNT_W acked beats;  rd_cnt_o/wr_cnt_o out CNT_W acked reads/writes;  err_cnt_o out CNT_W error cycles
// BEHAVIOUR
//  Reset: all outputs and internal state go to 0 (state IDLE).
//  Sampling: inputs are sampled at posedge; outputs are registered and update 1 cycle after the violating sample.
//  Checks:
//   0 STB_NO_CYC : stb=1 while cyc=0 (3.25)
//   1 SPUR_ACK   : ack=1 while !(cyc&stb) (3.35)
//   2 TIMEOUT    : ACK_TIMEOUT consecutive cyc&stb&!ack cycles
//   3 UNSTABLE   : in WAIT, adr/we/sel differ from the captured beat, or dat differs when we=1 (checked through the ack cycle)
//   4 POST_RST   : cyc|stb=1 on the first posedge after wb_rst_i deasserts (3.00)
//   5 SEL_ZERO   : cyc&stb with sel==0
//  FSM (beat tracker):
//   IDLE ->WAIT    on cyc&stb&!ack. Capture adr/we/sel/dat and set wcnt=1.
//   IDLE stays     on cyc&stb&ack (zero-wait beat).
//   WAIT ->IDLE    on ack, or when !(cyc&stb); a dropped request is not an error.
//   WAIT           wcnt++ each unacked cycle; when wcnt==ACK_TIMEOUT, fire check 2 once and go to STALL.
//   STALL ->IDLE   on ack or !(cyc&stb). No repeat timeout in STALL; checks 3 and 5 stay active.
//   In WAIT, an ack with cyc&stb still high on the next cycle starts a new beat (recapture via IDLE logic in the same cycle).
//  Counters: each beat with cyc&stb&ack increments txn_cnt, plus rd_cnt or wr_cnt by we.
//   err_cnt increments once per cycle with any check firing. All counters saturate at all-ones (no wrap).
//  clr_i: zeroes flags and counters next cycle; FSM is unaffected.
//   clr_i together with a new error: the error wins (flag set, err_cnt=1).
//   clr_i together with an acked beat: the counter becomes 1.
//  Reset mid-beat: immediate return to IDLE. The partial beat is not counted; POST_RST is armed.
//  Several checks in one cycle: all corresponding flags set; err_cnt +1 only.
// CONFIGURATION
//  WB_MON_CAPTURE_EN defined: adds outputs
//   first_err_code_o out 6  flag vector of the first error cycle
//   first_err_adr_o  out AW wb_adr_i at that cycle
//   first_err_vld_o  out 1  capture valid
//   Capture freezes at the first error after reset or clr_i; reset values are 0.
//  WB_MON_CAPTURE_EN undefined: these ports and their registers do not exist; all other behaviour is identical.
// TESTING
//  1 reset then 8 zero-wait writes, 4 reads (sel=4'hF) -> txn=12, wr=8, rd=4, err_flags=0, err_pulse never high
//  2 ACK_TIMEOUT=16, cyc&stb held with ack at cycle 20 -> flag[2] and err_pulse exactly 1 cycle after the 16th unacked cycle; err_cnt=1; txn=1
//  3 stb=1, cyc=0 for 3 cycles -> flag[0], err_cnt=3; ack with stb=0 -> flag[1]
//  4 in WAIT change adr 0x100->0x104 before ack -> flag[3]; read beat with changing dat_i -> no error
//  5 cyc=stb=1 at first edge after reset release -> flag[4]; sel=0 on active beat -> flag[5]
//  6 clr_i in the same cycle as an error, and txn_cnt preset to 0xFFFF -> flag kept, err_cnt=1; saturation holds at 0xFFFF
//    With WB_MON_CAPTURE_EN: first_err_adr_o = address of the first error only

Source files
------------

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone B3 classic-cycle protocol checker for the SDRAM controller host port.
// Flags STB without CYC, spurious ACK, ACK timeout, request drift inside a beat, activity on the
// first edge after reset, and SEL==0 on an active request. Keeps saturating traffic/error counters.
// Optional first-error capture ports are built when WB_MON_CAPTURE_EN is defined.
module wb_protocol_monitor #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int SW          = DW / 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [SW-1:0]    wb_sel_i,
    input  logic [AW-1:0]    wb_adr_i,
    input  logic [DW-1:0]    wb_dat_i,
    input  logic             wb_ack_o,
    input  logic             clr_i,
    output logic [5:0]       err_flags_o,
    output logic             err_pulse_o,
    output logic [CNT_W-1:0] txn_cnt_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
`ifdef WB_MON_CAPTURE_EN
    ,
    output logic [5:0]       first_err_code_o,
    output logic [AW-1:0]    first_err_adr_o,
    output logic             first_err_vld_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [15:0] TO_LIM = 16'(ACK_TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [15:0]     wcnt_q, wcnt_d;
    logic [AW-1:0]   cap_adr_q, cap_adr_d;
    logic            cap_we_q, cap_we_d;
    logic [SW-1:0]   cap_sel_q, cap_sel_d;
    logic [DW-1:0]   cap_dat_q, cap_dat_d;
    logic            post_seen_q, post_seen_d;
    logic [5:0]      flags_q, flags_d;
    logic            pulse_q, pulse_d;
    logic [CNT_W-1:0] txn_q, txn_d, rd_q, rd_d, wr_q, wr_d, err_q, err_d;

    logic            req_s, beat_s, drift_s, tmo_s;
    logic [5:0]      chk_s;

    // Qualify the sampled request and evaluate every rule for this cycle
    always_comb begin
        req_s   = wb_cyc_i & wb_stb_i;
        beat_s  = req_s & wb_ack_o;
        drift_s = (wb_adr_i != cap_adr_q) || (wb_we_i != cap_we_q) || (wb_sel_i != cap_sel_q) ||
                  (cap_we_q && (wb_dat_i != cap_dat_q));
        // wcnt_q counts unacked cycles already seen; this cycle would be one more
        tmo_s   = (state_q == ST_WAIT) && req_s && !wb_ack_o && ((wcnt_q + 16'd1) == TO_LIM);
        chk_s    = 6'd0;
        chk_s[0] = wb_stb_i & ~wb_cyc_i;
        chk_s[1] = wb_ack_o & ~req_s;
        chk_s[2] = tmo_s;
        chk_s[3] = ((state_q == ST_WAIT) || (state_q == ST_STALL)) && req_s && drift_s;
        chk_s[4] = ~post_seen_q & (wb_cyc_i | wb_stb_i);
        chk_s[5] = req_s && (wb_sel_i == {SW{1'b0}});
    end

    // Beat tracker: captures the request on its first unacked cycle and times the wait
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        cap_adr_d   = cap_adr_q;
        cap_we_d    = cap_we_q;
        cap_sel_d   = cap_sel_q;
        cap_dat_d   = cap_dat_q;
        post_seen_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (req_s && !wb_ack_o) begin
                    state_d   = ST_WAIT;
                    wcnt_d    = 16'd1;
                    cap_adr_d = wb_adr_i;
                    cap_we_d  = wb_we_i;
                    cap_sel_d = wb_sel_i;
                    cap_dat_d = wb_dat_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_s || wb_ack_o) begin
                    state_d = ST_IDLE;
                end else if (tmo_s) begin
                    state_d = ST_STALL;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            ST_STALL: begin
                if (!req_s || wb_ack_o) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STALL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags and saturating counters; a same-cycle event overrides clr_i
    always_comb begin
        if (clr_i) begin
            flags_d = 6'd0;
            txn_d   = {CNT_W{1'b0}};
            rd_d    = {CNT_W{1'b0}};
            wr_d    = {CNT_W{1'b0}};
            err_d   = {CNT_W{1'b0}};
        end else begin
            flags_d = flags_q;
            txn_d   = txn_q;
            rd_d    = rd_q;
            wr_d    = wr_q;
            err_d   = err_q;
        end
        flags_d = flags_d | chk_s;
        pulse_d = |chk_s;
        if (|chk_s) begin
            err_d = sat_inc(err_d);
        end else begin
            err_d = err_d;
        end
        if (beat_s) begin
            txn_d = sat_inc(txn_d);
            if (wb_we_i) begin
                wr_d = sat_inc(wr_d);
            end else begin
                rd_d = sat_inc(rd_d);
            end
        end else begin
            txn_d = txn_d;
        end
    end

    // State, capture and reporting registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 16'd0;
            cap_adr_q   <= {AW{1'b0}};
            cap_we_q    <= 1'b0;
            cap_sel_q   <= {SW{1'b0}};
            cap_dat_q   <= {DW{1'b0}};
            post_seen_q <= 1'b0;
            flags_q     <= 6'd0;
            pulse_q     <= 1'b0;
            txn_q       <= {CNT_W{1'b0}};
            rd_q        <= {CNT_W{1'b0}};
            wr_q        <= {CNT_W{1'b0}};
            err_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            cap_adr_q   <= cap_adr_d;
            cap_we_q    <= cap_we_d;
            cap_sel_q   <= cap_sel_d;
            cap_dat_q   <= cap_dat_d;
            post_seen_q <= post_seen_d;
            flags_q     <= flags_d;
            pulse_q     <= pulse_d;
            txn_q       <= txn_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
        end
    end

    assign err_flags_o = flags_q;
    assign err_pulse_o = pulse_q;
    assign txn_cnt_o   = txn_q;
    assign rd_cnt_o    = rd_q;
    assign wr_cnt_o    = wr_q;
    assign err_cnt_o   = err_q;

`ifdef WB_MON_CAPTURE_EN
    logic [5:0]    fcode_q, fcode_d;
    logic [AW-1:0] fadr_q, fadr_d;
    logic          fvld_q, fvld_d;

    // Freeze the first error cycle seen since reset or the last clear
    always_comb begin
        if (clr_i) begin
            fcode_d = 6'd0;
            fadr_d  = {AW{1'b0}};
            fvld_d  = 1'b0;
        end else begin
            fcode_d = fcode_q;
            fadr_d  = fadr_q;
            fvld_d  = fvld_q;
        end
        if ((|chk_s) && (clr_i || !fvld_q)) begin
            fcode_d = chk_s;
            fadr_d  = wb_adr_i;
            fvld_d  = 1'b1;
        end else begin
            fvld_d = fvld_d;
        end
    end

    // First-error capture registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            fcode_q <= 6'd0;
            fadr_q  <= {AW{1'b0}};
            fvld_q  <= 1'b0;
        end else begin
            fcode_q <= fcode_d;
            fadr_q  <= fadr_d;
            fvld_q  <= fvld_d;
        end
    end

    assign first_err_code_o = fcode_q;
    assign first_err_adr_o  = fadr_q;
    assign first_err_vld_o  = fvld_q;
`endif

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Self-checking bench for wb_protocol_monitor: vector table, directed corner sequences and
// randomized traffic scored against a rule-level reference model.
module tb_wb_protocol_monitor;
    localparam int TO   = 16;
    localparam int CMAX = 65535;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we, ack, clr;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic [5:0]  flags;
    logic        pulse;
    logic [15:0] txn, rd, wr, errc;
`ifdef WB_MON_CAPTURE_EN
    logic [5:0]  fcode;
    logic [31:0] fadr;
    logic        fvld;
`endif

    always #5 clk = ~clk;

    wb_protocol_monitor #(.DW(32), .AW(32), .ACK_TIMEOUT(TO), .CNT_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_ack_o(ack), .clr_i(clr),
        .err_flags_o(flags), .err_pulse_o(pulse), .txn_cnt_o(txn), .rd_cnt_o(rd),
        .wr_cnt_o(wr), .err_cnt_o(errc)
`ifdef WB_MON_CAPTURE_EN
        , .first_err_code_o(fcode), .first_err_adr_o(fadr), .first_err_vld_o(fvld)
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    // reference model state: length of the current unacked request run and its first-cycle values
    int          m_run, m_txn, m_rd, m_wr, m_err;
    bit          m_seen, m_pulse;
    logic [5:0]  m_flags;
    logic [31:0] r_adr, r_dat;
    logic        r_we;
    logic [3:0]  r_sel;
    bit          m_fvld;
    logic [5:0]  m_fcode;
    logic [31:0] m_fadr;

    typedef struct {
        logic       cyc, stb, ack;
        logic [3:0] sel;
        logic [5:0] e_flags;
        logic       e_pulse;
        int         e_err;
        int         e_txn;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic m_reset();
        m_run = 0; m_txn = 0; m_rd = 0; m_wr = 0; m_err = 0;
        m_seen = 1'b0; m_pulse = 1'b0; m_flags = 6'd0;
        m_fvld = 1'b0; m_fcode = 6'd0; m_fadr = 32'd0;
    endtask

    // apply the protocol rules to the inputs sampled at this edge
    task automatic m_update();
        logic       req;
        logic [5:0] c;
        req = cyc & stb;
        c = 6'd0;
        if (stb && !cyc) c[0] = 1'b1;
        if (ack && !req) c[1] = 1'b1;
        if (req && m_run > 0 && (adr != r_adr || we != r_we || sel != r_sel || (r_we && dat != r_dat)))
            c[3] = 1'b1;
        if (!m_seen && (cyc || stb)) c[4] = 1'b1;
        if (req && sel == 4'd0) c[5] = 1'b1;
        if (req && !ack) begin
            if (m_run == 0) begin
                r_adr = adr; r_we = we; r_sel = sel; r_dat = dat;
            end
            m_run++;
            if (m_run == TO) c[2] = 1'b1;
        end else begin
            m_run = 0;
        end
        m_seen = 1'b1;
        if (clr) begin
            m_flags = 6'd0; m_txn = 0; m_rd = 0; m_wr = 0; m_err = 0;
            m_fvld = 1'b0; m_fcode = 6'd0; m_fadr = 32'd0;
        end
        m_flags = m_flags | c;
        m_pulse = (c != 6'd0);
        if (c != 6'd0) m_err = sat(m_err);
        if (req && ack) begin
            m_txn = sat(m_txn);
            if (we) m_wr = sat(m_wr);
            else m_rd = sat(m_rd);
        end
        if (c != 6'd0 && !m_fvld) begin
            m_fvld = 1'b1; m_fcode = c; m_fadr = adr;
        end
    endtask

    task automatic m_compare();
        check("flags", flags, m_flags);
        check("pulse", pulse, m_pulse);
        check("txn", txn, m_txn);
        check("rd", rd, m_rd);
        check("wr", wr, m_wr);
        check("errcnt", errc, m_err);
`ifdef WB_MON_CAPTURE_EN
        check("fvld", fvld, m_fvld);
        check("fcode", fcode, m_fcode);
        check("fadr", fadr, m_fadr);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        m_update();
        #1;
        m_compare();
    endtask

    task automatic set_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; ack = 1'b0; clr = 1'b0;
        sel = 4'hF; adr = 32'd0; dat = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_reset();
        check("rst_flags", flags, 0);
        check("rst_pulse", pulse, 0);
        check("rst_txn", txn, 0);
        check("rst_errcnt", errc, 0);
        rst = 1'b0;
    endtask

    task automatic do_clear();
        set_idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic beat(input logic w, input logic [31:0] a);
        cyc = 1'b1; stb = 1'b1; we = w; ack = 1'b1; sel = 4'hF; adr = a; dat = a ^ 32'hA5A5_0000;
    endtask

    initial begin
        bit slow;
        tbl[0] = '{1'b1, 1'b1, 1'b1, 4'hF, 6'b010000, 1'b1, 1, 1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'hF, 6'b010001, 1'b1, 2, 1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'hF, 6'b010001, 1'b1, 3, 1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 4'hF, 6'b010001, 1'b1, 4, 1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 4'hF, 6'b010011, 1'b1, 5, 1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 4'h0, 6'b110011, 1'b1, 6, 2};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 4'hF, 6'b110011, 1'b0, 6, 2};

        set_idle();
        rst = 1'b0;
        #2;
        do_reset();

        // vector table: post-reset activity, STB without CYC, spurious ACK, SEL zero
        for (int i = 0; i < 7; i++) begin
            set_idle();
            cyc = tbl[i].cyc; stb = tbl[i].stb; ack = tbl[i].ack; sel = tbl[i].sel;
            step();
            check($sformatf("tbl%0d_pulse", i), pulse, tbl[i].e_pulse);
            check($sformatf("tbl%0d_flags", i), flags, tbl[i].e_flags);
            check($sformatf("tbl%0d_err", i), errc, tbl[i].e_err);
            check($sformatf("tbl%0d_txn", i), txn, tbl[i].e_txn);
        end

        // 8 zero-wait writes then 4 reads: clean traffic
        do_clear();
        for (int i = 0; i < 12; i++) begin
            beat(i < 8, 32'(i * 4));
            step();
            check("clean_pulse", pulse, 0);
        end
        set_idle();
        step();
        check("clean_txn", txn, 12);
        check("clean_wr", wr, 8);
        check("clean_rd", rd, 4);
        check("clean_flags", flags, 0);

        // held request acked on cycle 20: timeout pulse right after the 16th unacked cycle
        do_clear();
        for (int i = 1; i <= 20; i++) begin
            cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h300; ack = (i == 20);
            step();
            check($sformatf("tmo_pulse_c%0d", i), pulse, (i == 16));
        end
        set_idle();
        step();
        check("tmo_flags", flags, 6'b000100);
        check("tmo_err", errc, 1);
        check("tmo_txn", txn, 1);

        // address drift inside a write beat
        do_clear();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h100; dat = 32'h11; ack = 1'b0;
        step();
        adr = 32'h104;
        step();
        check("drift_flag", flags, 6'b001000);
        ack = 1'b1;
        step();
        // read beat with wandering data is fine
        do_clear();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h200; dat = 32'd1; ack = 1'b0;
        step();
        dat = 32'd2;
        step();
        dat = 32'd3; ack = 1'b1;
        step();
        check("rd_data_flags", flags, 0);
        check("rd_data_rd", rd, 1);

        // clear and error in the same cycle: error wins
        set_idle();
        clr = 1'b1; stb = 1'b1;
        step();
        check("clr_err_flags", flags, 6'b000001);
        check("clr_err_cnt", errc, 1);

        // saturation of the beat counters
        do_clear();
        for (int i = 0; i < 65540; i++) begin
            beat(1'b1, 32'h40);
            step();
        end
        check("sat_txn", txn, 16'hFFFF);
        check("sat_wr", wr, 16'hFFFF);
        clr = 1'b1;
        step();
        check("clr_beat_txn", txn, 1);
        set_idle();
        step();

`ifdef WB_MON_CAPTURE_EN
        do_clear();
        cyc = 1'b1; stb = 1'b1; ack = 1'b1; sel = 4'h0; adr = 32'h40;
        step();
        set_idle();
        stb = 1'b1; adr = 32'h80;
        step();
        check("cap_adr", fadr, 32'h40);
        check("cap_code", fcode, 6'b100000);
        check("cap_vld", fvld, 1);
        set_idle();
        step();
`endif

        // randomized traffic against the model
        slow = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) slow = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) < 12) begin
                adr = $urandom; dat = $urandom;
                we = 1'($urandom_range(0, 1)); sel = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 99) < 5) begin
                dat = $urandom;
            end
            if (slow) begin
                cyc = ($urandom_range(0, 99) < 98);
                stb = cyc;
                ack = ($urandom_range(0, 99) < 2);
            end else begin
                cyc = ($urandom_range(0, 99) < 85);
                stb = cyc ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 5);
                ack = ($urandom_range(0, 99) < 45);
            end
            clr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            step();
        end

        // reset in the middle of a beat: partial beat dropped
        do_clear();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h500; ack = 1'b0;
        step();
        step();
        do_reset();
        set_idle();
        step();
        check("midrst_txn", txn, 0);
        check("midrst_flags", flags, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
